seu_shift_reg_tester: RTL and testbench
=======================================

// Module: seu_shift_reg_tester
// PURPOSE
//  Pattern driver and checker for the SEU test shift register (single chain, LENGTH stages).
//  Drives the chain's data_in/mode with a PRBS7 stream and compares the chain's data_out
//  against a delayed copy of that stream; counts mismatches caused by upsets in the chain.
//  Sits directly around the chain: upstream of its inputs, downstream of its output; same clock.
// PARAMETERS
//  LENGTH   50  stages in the attached shift register; must equal the chain's LENGTH
//  ERR_W    16  width of the saturating error counter
//  SEED     7'h7F  PRBS7 start value for both generator and checker LFSR; must be nonzero
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      1-cycle request: begin fill + run; ignored unless IDLE
//  stop         in   1      1-cycle request: return to IDLE; ignored in IDLE
//  clear_cnt    in   1      synchronous clear of err_count and err_flag
//  sr_data_out  in   1      serial output of the shift register under test
//  sr_data_in   out  1      serial input to the shift register under test
//  sr_mode      out  1      1 = chain shifts, 0 = chain holds contents
//  busy         out  1      1 in FILL or RUN
//  checking     out  1      1 in RUN (comparisons active)
//  err_count    out  ERR_W  number of mismatches since last clear, saturates at all-ones
//  err_flag     out  1      sticky, set on first mismatch
// BEHAVIOUR
//  Reset: state=IDLE, both LFSRs=SEED, fill counter=0, err_count=0, err_flag=0;
//   sr_mode=0, sr_data_in=0, busy=0, checking=0. Chain contents are not touched by reset.
//  LFSR (gen and chk): next = {l[5:0], l[6]^l[5]}; output bit = l[6]. From 7'h7F: 1111111 0 ...
//  FSM (registered state): IDLE -> FILL on start. FILL -> RUN after exactly LENGTH clocks
//   in FILL. RUN -> IDLE on stop. FILL -> IDLE on stop (no comparisons performed).
//  sr_mode = busy (decoded from state flops); sr_data_in = gen_lfsr[6] when busy, else 0.
//  Gen LFSR advances every busy cycle; reloads SEED on entry to FILL.
//  Chk LFSR reloads SEED on entry to RUN; advances every RUN cycle.
//  Latency: bit driven on sr_data_in at FILL cycle k is sampled on sr_data_out at RUN cycle k
//   (LENGTH clocks later); compare sr_data_out vs chk_lfsr[6] on every RUN clock edge.
//  Mismatch in RUN: err_count += 1 unless all-ones (saturate); err_flag <= 1.
//  clear_cnt same cycle as mismatch: clear wins (count=0, flag=0).
//  start and stop same cycle in IDLE: start wins. start in FILL/RUN ignored (no restart).
//  Stop: sr_mode drops to 0 the cycle after stop; chain freezes holding last data.
//  Counter/flag persist across IDLE and new start; only clear_cnt or rst_n clears them.
//  Fill counter width $clog2(LENGTH+1); LENGTH>=2 required.
//  No synchroniser on sr_data_out: chain is on clk.
// TESTING
//  1 Reset asserted mid-RUN -> next cycle all outputs 0, state IDLE; err_count=0.
//  2 Loopback to LENGTH=50 chain model, start, run 1000 cycles -> checking rises exactly
//    50 clocks after busy, err_count=0, first 7 bits on sr_data_in = 1, 8th = 0.
//  3 Flip one chain stage at RUN cycle 100 -> err_count=1, err_flag=1, no further errors.
//  4 Force sr_data_out=0 for first 10 RUN cycles -> err_count=7 (ones in first 10 PRBS bits).
//  5 ERR_W=4, sr_data_out = ~expected for 40 RUN cycles -> err_count stays at 15, flag=1.
//  6 stop at FILL cycle 20 -> IDLE next cycle, sr_mode=0, err_count unchanged; then
//    clear_cnt with concurrent mismatch -> err_count=0, err_flag=0.

Source files
------------

// File: rtl/seu_shift_reg_tester.sv
// seu_shift_reg_tester
// Drives a PRBS7 pattern into a single serial SEU test chain of LENGTH stages.
// Compares the chain output against a re-seeded copy of the same stream.
// Counts mismatches in a saturating counter with a sticky flag.
module seu_shift_reg_tester #(
   parameter int         LENGTH = 50,
   parameter int         ERR_W  = 16,
   parameter logic [6:0] SEED   = 7'h7F
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             clear_cnt,
   input  logic             sr_data_out,
   output logic             sr_data_in,
   output logic             sr_mode,
   output logic             busy,
   output logic             checking,
   output logic [ERR_W-1:0] err_count,
   output logic             err_flag
);

   localparam int                 CNT_W     = $clog2(LENGTH + 1);
   localparam logic [CNT_W-1:0]   FILL_LAST = CNT_W'(LENGTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FILL = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_fill_cnt;
   logic [6:0]       r_gen_lfsr;
   logic [6:0]       r_chk_lfsr;
   logic [ERR_W-1:0] r_err_count;
   logic             r_err_flag;

   logic [1:0]       w_next_state;
   logic             w_busy;
   logic             w_run;
   logic             w_fill_entry;
   logic             w_run_entry;
   logic             w_mismatch;

   // PRBS7 step: shift left, feed back tap 7 xor tap 6
   function automatic logic [6:0] lfsr_next(input logic [6:0] l);
      return {l[5:0], l[6] ^ l[5]};
   endfunction

   // Increment that sticks at all-ones
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   assign w_busy       = (r_state == S_FILL) || (r_state == S_RUN);
   assign w_run        = (r_state == S_RUN);
   assign w_fill_entry = (r_state == S_IDLE) && start;
   assign w_run_entry  = (r_state == S_FILL) && (w_next_state == S_RUN);
   assign w_mismatch   = w_run && (sr_data_out != r_chk_lfsr[6]);

   // Next-state decode: start only honoured in IDLE, stop only outside IDLE
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (start) w_next_state = S_FILL;
         S_FILL: begin
            if (stop)                          w_next_state = S_IDLE;
            else if (r_fill_cnt == FILL_LAST)  w_next_state = S_RUN;
         end
         S_RUN:  if (stop) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register and fill counter (counts FILL cycles, zero outside FILL)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_fill_cnt <= '0;
      end else begin
         r_state    <= w_next_state;
         r_fill_cnt <= ((r_state == S_FILL) && (w_next_state == S_FILL)) ?
                       r_fill_cnt + 1'b1 : '0;
      end
   end

   // Generator LFSR: reseeded when a fill begins, steps while the chain shifts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            r_gen_lfsr <= SEED;
      else if (w_fill_entry) r_gen_lfsr <= SEED;
      else if (w_busy)       r_gen_lfsr <= lfsr_next(r_gen_lfsr);
   end

   // Checker LFSR: reseeded as the first filled bit reaches the chain output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           r_chk_lfsr <= SEED;
      else if (w_run_entry) r_chk_lfsr <= SEED;
      else if (w_run)       r_chk_lfsr <= lfsr_next(r_chk_lfsr);
   end

   // Error accounting: clear takes priority over a simultaneous mismatch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_count <= '0;
         r_err_flag  <= 1'b0;
      end else if (clear_cnt) begin
         r_err_count <= '0;
         r_err_flag  <= 1'b0;
      end else if (w_mismatch) begin
         r_err_count <= sat_inc(r_err_count);
         r_err_flag  <= 1'b1;
      end
   end

   assign busy       = w_busy;
   assign checking   = w_run;
   assign sr_mode    = w_busy;
   assign sr_data_in = w_busy & r_gen_lfsr[6];
   assign err_count  = r_err_count;
   assign err_flag   = r_err_flag;

endmodule

// File: tb/tb_seu_shift_reg_tester.sv
// tb_seu_shift_reg_tester
// Directed bench: DUT A (LENGTH=50, ERR_W=16) is looped through a 50-stage
// chain model; DUT B (ERR_W=4) is driven directly to exercise saturation.
module tb_seu_shift_reg_tester;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // DUT A signals
   logic        a_start = 1'b0, a_stop = 1'b0, a_clear = 1'b0;
   logic        a_sdo, a_sdi, a_mode, a_busy, a_checking, a_flag;
   logic [15:0] a_count;

   // DUT B signals
   logic        b_start = 1'b0, b_stop = 1'b0, b_sdo = 1'b0;
   logic        b_sdi, b_mode, b_busy, b_checking, b_flag;
   logic [3:0]  b_count;

   // Chain model and fault injection
   logic [49:0] chain = '0;
   logic [49:0] flip_mask = '0;
   logic        a_ovr = 1'b0, a_ovr_val = 1'b0;

   int n_pass = 0, n_fail = 0, n_total = 0;
   logic [6:0] m;
   logic       any_chk;
   logic [7:0] exp8;

   always #5 clk = ~clk;

   assign a_sdo = a_ovr ? a_ovr_val : chain[49];

   // Shift register under test, with optional single-cycle bit flips
   always @(posedge clk) begin
      if (a_mode) chain <= {chain[48:0], a_sdi} ^ flip_mask;
   end

   seu_shift_reg_tester #(.LENGTH(50), .ERR_W(16), .SEED(7'h7F)) u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .stop(a_stop),
      .clear_cnt(a_clear), .sr_data_out(a_sdo), .sr_data_in(a_sdi),
      .sr_mode(a_mode), .busy(a_busy), .checking(a_checking),
      .err_count(a_count), .err_flag(a_flag));

   seu_shift_reg_tester #(.LENGTH(50), .ERR_W(4), .SEED(7'h7F)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop),
      .clear_cnt(1'b0), .sr_data_out(b_sdo), .sr_data_in(b_sdi),
      .sr_mode(b_mode), .busy(b_busy), .checking(b_checking),
      .err_count(b_count), .err_flag(b_flag));

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      step(3);
      check("rst_a_outs", {a_busy, a_checking, a_mode, a_sdi, a_flag}, 0);
      check("rst_a_cnt", a_count, 0);
      check("rst_b_outs", {b_busy, b_checking, b_mode, b_sdi, b_flag, b_count}, 0);
      rst_n = 1'b1;
      step(2);

      // Fill latency, first PRBS bits, clean run
      exp8 = 8'b1111_1110;
      any_chk = 1'b0;
      a_start = 1'b1; step(1); a_start = 1'b0;
      check("fill_busy", {a_busy, a_mode}, 2'b11);
      for (int i = 0; i < 50; i++) begin
         if (i < 8) check($sformatf("prbs_bit%0d", i), a_sdi, exp8[7-i]);
         any_chk = any_chk | a_checking;
         if (i < 49) step(1);
      end
      check("no_check_in_fill", any_chk, 0);
      step(1);
      check("checking_at_50", {a_busy, a_checking}, 2'b11);
      step(999);
      check("clean_run_cnt", a_count, 0);
      check("clean_run_flag", a_flag, 0);
      a_start = 1'b1; step(1); a_start = 1'b0;
      check("start_ignored_run", a_checking, 1);
      a_stop = 1'b1; step(1); a_stop = 1'b0;
      check("stop_run_idle", {a_busy, a_checking, a_mode, a_sdi}, 0);

      // Single upset in the chain at RUN cycle 100
      a_start = 1'b1; step(1); a_start = 1'b0;
      step(50);
      step(100);
      flip_mask = 50'd1 << 10;
      step(1);
      flip_mask = '0;
      step(199);
      check("seu_cnt", a_count, 1);
      check("seu_flag", a_flag, 1);
      step(300);
      check("seu_cnt_later", a_count, 1);

      // Reset asserted mid-RUN
      rst_n = 1'b0;
      step(1);
      check("rst_mid_outs", {a_busy, a_checking, a_mode, a_sdi, a_flag}, 0);
      check("rst_mid_cnt", a_count, 0);
      rst_n = 1'b1;
      step(1);

      // Output stuck at 0 for the first 10 RUN cycles
      a_start = 1'b1; step(1); a_start = 1'b0;
      step(49);
      a_ovr = 1'b1; a_ovr_val = 1'b0;
      step(11);
      a_ovr = 1'b0;
      check("stuck0_cnt", a_count, 7);
      step(100);
      check("stuck0_cnt_later", a_count, 7);
      check("stuck0_flag", a_flag, 1);
      a_stop = 1'b1; step(1); a_stop = 1'b0;

      // Stop during FILL, then clear colliding with a mismatch
      a_start = 1'b1; step(1); a_start = 1'b0;
      step(20);
      a_stop = 1'b1; step(1); a_stop = 1'b0;
      check("stop_fill_idle", {a_busy, a_mode, a_sdi, a_checking}, 0);
      check("stop_fill_cnt", a_count, 7);
      a_start = 1'b1; a_stop = 1'b1; step(1); a_start = 1'b0; a_stop = 1'b0;
      check("start_beats_stop", a_busy, 1);
      step(50);
      check("refill_run", a_checking, 1);
      a_ovr = 1'b1; a_ovr_val = 1'b0; a_clear = 1'b1;
      step(1);
      a_ovr = 1'b0; a_clear = 1'b0;
      check("clear_wins_cnt", a_count, 0);
      check("clear_wins_flag", a_flag, 0);
      step(20);
      check("after_clear_cnt", {a_flag, a_count}, 0);

      // Saturation on the 4-bit counter
      b_start = 1'b1; step(1); b_start = 1'b0;
      step(50);
      check("b_run", b_checking, 1);
      m = 7'h7F;
      for (int i = 0; i < 40; i++) begin
         b_sdo = ~m[6];
         step(1);
         m = {m[5:0], m[6] ^ m[5]};
         if (i == 9)  check("sat_cnt10", b_count, 10);
         if (i == 15) check("sat_cnt16", b_count, 15);
      end
      check("sat_cnt40", b_count, 15);
      check("sat_flag", b_flag, 1);
      b_sdo = 1'b0;
      b_stop = 1'b1; step(1); b_stop = 1'b0;
      check("b_stop_idle", {b_busy, b_mode}, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
